// File: rtl/rgb_pwm_pkg.sv
// Shared constants for the RGB fade PWM block: breathe FSM encoding and default sizing.
package rgb_pwm_pkg;

  localparam logic ST_UP   = 1'b0;
  localparam logic ST_DOWN = 1'b1;

  localparam int CH_DEF   = 3;
  localparam int N_DEF    = 16;
  localparam int DW_DEF   = 8;
  localparam int STEP_DEF = 1;

endpackage

// File: rtl/rgb_fade_pwm_counter.sv
// Free-running modulo-(M+1) counter with count enable E and synchronous clear T.
module rgb_fade_pwm_counter #(
  parameter int           N = 16,
  parameter logic [N-1:0] M = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         E,
  input  logic         T,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (T) begin
      q_d = '0;
    end else if (E) begin
      q_d = (q_q == M) ? '0 : q_q + N'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/rgb_fade_pwm.sv
// Multi-channel PWM with double-buffered duties (swapped at period end) and an optional
// shared triangle "breathe" level that scales every channel's duty.
module rgb_fade_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int CH   = CH_DEF,
  parameter int N    = N_DEF,
  parameter int DW   = DW_DEF,
  parameter int STEP = STEP_DEF,
  localparam int WW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          wr,
  input  logic [WW-1:0] wr_ch,
  input  logic [DW-1:0] wr_duty,
  input  logic          breathe,
  output logic [CH-1:0] RGB,
  output logic          period_end
);

  localparam logic [DW-1:0] LMAX   = {DW{1'b1}};
  localparam logic [DW:0]   STEP_W = (DW+1)'(STEP);

  logic [N-1:0]  cnt;
  logic [DW-1:0] phase;
  logic          wr_ok;
  logic          mode_q, mode_d;
  logic          st_q, st_d;
  logic [DW-1:0] lvl_q, lvl_d;
  logic [DW:0]   lvl_sum;

  rgb_fade_pwm_counter #(
    .N (N),
    .M ({N{1'b1}})
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .E   (en),
    .T   (1'b0),
    .q_o (cnt)
  );

  assign period_end = en && (cnt == {N{1'b1}});
  assign phase      = cnt[N-1 -: DW];
  assign wr_ok      = wr && (32'(wr_ch) < CH);

  // Mode and level advance only at period boundaries so a pulse never changes mid-period.
  always_comb begin
    mode_d  = mode_q;
    st_d    = st_q;
    lvl_d   = lvl_q;
    lvl_sum = {1'b0, lvl_q} + STEP_W;
    if (period_end) begin
      mode_d = breathe;
      if (!mode_q) begin
        lvl_d = '0;
        st_d  = ST_UP;
      end else if (st_q == ST_UP) begin
        if (lvl_sum >= {1'b0, LMAX}) begin
          lvl_d = LMAX;
          st_d  = ST_DOWN;
        end else begin
          lvl_d = lvl_sum[DW-1:0];
        end
      end else begin
        if ({1'b0, lvl_q} <= STEP_W) begin
          lvl_d = '0;
          st_d  = ST_UP;
        end else begin
          lvl_d = lvl_q - STEP_W[DW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      st_q   <= ST_UP;
      lvl_q  <= '0;
    end else begin
      mode_q <= mode_d;
      st_q   <= st_d;
      lvl_q  <= lvl_d;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic          hit;
    logic [DW-1:0] pend_q, pend_d, act_q, act_d, eff;
    logic [2*DW-1:0] prod;
    logic          rgb_q, rgb_d;

    assign hit    = wr_ok && (wr_ch == WW'(c));
    assign pend_d = hit ? wr_duty : pend_q;
    // A write landing on the boundary edge goes straight to the active duty.
    assign act_d  = period_end ? pend_d : act_q;
    assign prod   = {{DW{1'b0}}, act_q} * {{DW{1'b0}}, lvl_q};
    assign eff    = mode_q ? prod[2*DW-1:DW] : act_q;
    assign rgb_d  = en && (phase < eff);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_q <= '0;
        act_q  <= '0;
        rgb_q  <= 1'b0;
      end else begin
        pend_q <= pend_d;
        act_q  <= act_d;
        rgb_q  <= rgb_d;
      end
    end

    assign RGB[c] = rgb_q;
  end

endmodule
